mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: CLK  in  1  system clock; RST  in  1  reset, asynchronous, active-high.
REQ-002 SHALL have ports: ex_dREN, ex_dWEN, ex_RegWr, ex_halt  in  1 each  EX/MEM control; ex_MemToReg  in  3  writeback select.
REQ-003 SHALL have ports: ex_addr, ex_store, ex_pc4, ex_lui  in  32 each  ALU result, store data, PC+4, LUI value; ex_wsel  in  5  destination register.
REQ-004 SHALL have ports: ex_ll, ex_sc  in  1 each  load-linked / store-conditional flags.
REQ-005 SHALL have ports: flush  in  1  squash MEM/WB; dhit  in  1  cache done; dmemload  in  32  load data.
REQ-006 SHALL have ports: ccinv  in  1  snoop invalidate; ccsnoopaddr  in  32  snooped address.
REQ-007 SHALL have ports: dmemREN, dmemWEN  out  1 each; dmemaddr, dmemstore  out  32 each; mem_stall  out  1  freezes IF..EX/MEM.
REQ-008 SHALL have ports: wb_RegWr, wb_halt  out  1 each; wb_wsel  out  5; wb_wdat  out  32; halt  out  1  sticky halt to caches; wait_cnt  out  16  stall-cycle counter.

Function
REQ-009 SHALL run FSM IDLE, ACCESS, HALTED.
REQ-010 IDLE: if (ex_dREN|ex_dWEN) and !dhit, SHALL go ACCESS; if ex_halt, SHALL go HALTED; else stay.
REQ-011 ACCESS: on dhit SHALL return to IDLE; else stay.
REQ-012 HALTED SHALL be terminal until RST; halt=1 there.
REQ-013 dmemREN=ex_dREN, dmemWEN=ex_dWEN (gated by SC success, REQ-020), both 0 in HALTED; dmemaddr=ex_addr, dmemstore=ex_store, combinational.
REQ-014 mem_stall SHALL equal (dmemREN|dmemWEN)&!dhit; a same-cycle hit gives zero stall cycles.
REQ-015 MEM/WB register SHALL load on rising CLK when !mem_stall and !flush: wb_RegWr, wb_wsel, wb_halt from ex_*, wb_wdat per ex_MemToReg.
REQ-016 wb_wdat select: 0 ex_addr, 1 dmemload, 2 ex_pc4, 3 ex_lui, 4 SC result (0/1); others 0.
REQ-017 While mem_stall=1 or flush=1 SHALL load a bubble: wb_RegWr=0, wb_halt=0, wb_wsel=0, wb_wdat=0; flush wins over stall.
REQ-018 wait_cnt SHALL increment each cycle mem_stall=1, saturate at 16'hFFFF, never wrap.

Reset
REQ-019 RST SHALL force state IDLE, all wb_* outputs 0, halt 0, wait_cnt 0, link invalid, mid-access included; dmemREN/dmemWEN follow inputs after release.

Configuration
REQ-020 With LLSC_EN defined: link register (valid, 32b addr); LL completing on dhit sets valid, addr=ex_addr; SC with valid and addr match stores and writes 1, else no store (dmemWEN=0, no stall) and writes 0; any completed SC clears valid; completed store to linked addr clears valid; ccinv with ccsnoopaddr==link addr clears valid; ccinv same cycle as LL completion to same addr leaves valid=0.
REQ-021 Without LLSC_EN: no link register; ex_ll acts as plain load, ex_sc as plain store writing 1; ccinv, ccsnoopaddr ignored.

Structure
REQ-022 FSM state enum, MemToReg encodings, wait_cnt width SHALL live in cpu_types_pkg; word_t, regbits_t reused.
REQ-023 Link register SHALL be sub-module llsc_link, instantiated only under LLSC_EN.

Verification
REQ-024 Load ex_dREN=1, ex_addr=0x40, dhit low 3 cycles, dmemload=0xDEADBEEF -> mem_stall 3 cycles, 3 bubbles, then wb_wdat=0xDEADBEEF, wb_RegWr=1, wait_cnt=3.
REQ-025 Store with dhit same cycle -> dmemWEN=1 one cycle, mem_stall never 1, wait_cnt=0.
REQ-026 ex_halt=1 -> state HALTED, halt=1 permanently, later ex_dREN=1 -> dmemREN=0.
REQ-027 LLSC_EN: LL 0x80, SC 0x80 -> store issued, wb_wdat=1; LL 0x80, ccinv 0x80, SC 0x80 -> no dmemWEN, wb_wdat=0.
REQ-028 RST asserted mid ACCESS with wait_cnt=5 -> IDLE, wait_cnt=0, wb_* 0 immediately; flush with stall -> bubble.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word/register widths, MEM-stage FSM encoding, writeback selects.
// Consumed by mem_stage and llsc_link.
package cpu_types_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned WAIT_CNT_W = 16;
  localparam int unsigned MTR_W      = 3;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [REG_W-1:0]      regbits_t;
  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;
  typedef logic [MTR_W-1:0]      mtr_t;

  typedef enum logic [1:0] {
    MEM_IDLE   = 2'd0,
    MEM_ACCESS = 2'd1,
    MEM_HALTED = 2'd2
  } mem_state_t;

  // Writeback data select (ex_MemToReg)
  localparam mtr_t MTR_ALU = 3'd0;
  localparam mtr_t MTR_MEM = 3'd1;
  localparam mtr_t MTR_PC4 = 3'd2;
  localparam mtr_t MTR_LUI = 3'd3;
  localparam mtr_t MTR_SC  = 3'd4;

  typedef struct packed {
    logic     reg_wr;
    logic     halt;
    regbits_t wsel;
    word_t    wdat;
  } memwb_t;

endpackage

// File: rtl/llsc_link.sv
// Load-linked reservation: one valid bit plus the linked word address.
// Only instantiated when LLSC_EN is defined.
module llsc_link
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  ll_done,
  input  word_t ll_addr,
  input  logic  sc_done,
  input  logic  st_done,
  input  word_t st_addr,
  input  logic  ccinv,
  input  word_t ccsnoopaddr,
  output logic  link_valid,
  output word_t link_addr
);

  logic  valid_q, valid_d;
  word_t addr_q, addr_d;

  // A new link wins over stale clears, but a snoop of the very address being linked kills it.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (ll_done) begin
      addr_d  = ll_addr;
      valid_d = !(ccinv && (ccsnoopaddr == ll_addr));
    end else if (sc_done ||
                 (st_done && (st_addr == addr_q)) ||
                 (ccinv && (ccsnoopaddr == addr_q))) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign link_valid = valid_q;
  assign link_addr  = addr_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-cache handshake, stall/halt control and MEM/WB register.
// Define LLSC_EN to enable load-linked/store-conditional reservation tracking.
module mem_stage
  import cpu_types_pkg::*;
(
  input  logic      CLK,
  input  logic      RST,
  input  logic      ex_dREN,
  input  logic      ex_dWEN,
  input  logic      ex_RegWr,
  input  logic      ex_halt,
  input  mtr_t      ex_MemToReg,
  input  word_t     ex_addr,
  input  word_t     ex_store,
  input  word_t     ex_pc4,
  input  word_t     ex_lui,
  input  regbits_t  ex_wsel,
  input  logic      ex_ll,
  input  logic      ex_sc,
  input  logic      flush,
  input  logic      dhit,
  input  word_t     dmemload,
  input  logic      ccinv,
  input  word_t     ccsnoopaddr,
  output logic      dmemREN,
  output logic      dmemWEN,
  output word_t     dmemaddr,
  output word_t     dmemstore,
  output logic      mem_stall,
  output logic      wb_RegWr,
  output logic      wb_halt,
  output regbits_t  wb_wsel,
  output word_t     wb_wdat,
  output logic      halt,
  output wait_cnt_t wait_cnt
);

  mem_state_t state_q, state_d;
  wait_cnt_t  wait_cnt_q, wait_cnt_d;
  memwb_t     memwb_q, memwb_d;
  logic       halted;
  logic       sc_pass;
  logic       sc_result;

  assign halted = (state_q == MEM_HALTED);

`ifdef LLSC_EN
  logic  link_valid;
  word_t link_addr;
  logic  sc_ok;

  assign sc_ok     = link_valid && (link_addr == ex_addr);
  assign sc_pass   = !ex_sc || sc_ok;
  assign sc_result = sc_ok;

  // A failed SC never reaches the cache, so it completes without waiting for dhit.
  llsc_link u_llsc_link (
    .clk         (CLK),
    .rst         (RST),
    .ll_done     (ex_ll && ex_dREN && dhit && !halted),
    .ll_addr     (ex_addr),
    .sc_done     (ex_sc && ex_dWEN && !halted && (!sc_ok || dhit)),
    .st_done     (dmemWEN && dhit),
    .st_addr     (ex_addr),
    .ccinv       (ccinv),
    .ccsnoopaddr (ccsnoopaddr),
    .link_valid  (link_valid),
    .link_addr   (link_addr)
  );
`else
  logic unused_llsc;

  assign sc_pass     = 1'b1;
  assign sc_result   = 1'b1;
  assign unused_llsc = ^{ex_ll, ex_sc, ccinv, ccsnoopaddr};
`endif

  assign dmemREN   = ex_dREN && !halted;
  assign dmemWEN   = ex_dWEN && !halted && sc_pass;
  assign dmemaddr  = ex_addr;
  assign dmemstore = ex_store;
  assign mem_stall = (dmemREN || dmemWEN) && !dhit;

  // Next state, stall counter and MEM/WB payload
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    memwb_d    = '0;

    case (state_q)
      MEM_IDLE: begin
        if (mem_stall)    state_d = MEM_ACCESS;
        else if (ex_halt) state_d = MEM_HALTED;
      end
      MEM_ACCESS: begin
        if (!mem_stall) state_d = MEM_IDLE;
      end
      MEM_HALTED: state_d = MEM_HALTED;
      default:    state_d = MEM_IDLE;
    endcase

    if (mem_stall && (wait_cnt_q != '1)) wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);

    if (!mem_stall && !flush) begin
      memwb_d.reg_wr = ex_RegWr;
      memwb_d.halt   = ex_halt;
      memwb_d.wsel   = ex_wsel;
      case (ex_MemToReg)
        MTR_ALU: memwb_d.wdat = ex_addr;
        MTR_MEM: memwb_d.wdat = dmemload;
        MTR_PC4: memwb_d.wdat = ex_pc4;
        MTR_LUI: memwb_d.wdat = ex_lui;
        MTR_SC:  memwb_d.wdat = WORD_W'(sc_result);
        default: memwb_d.wdat = '0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= MEM_IDLE;
      wait_cnt_q <= '0;
      memwb_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      memwb_q    <= memwb_d;
    end
  end

  assign halt     = halted;
  assign wait_cnt = wait_cnt_q;
  assign wb_RegWr = memwb_q.reg_wr;
  assign wb_halt  = memwb_q.halt;
  assign wb_wsel  = memwb_q.wsel;
  assign wb_wdat  = memwb_q.wdat;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage; exercises the LL/SC path when built with LLSC_EN.
module tb_mem_stage;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      RST;
  logic      ex_dREN, ex_dWEN, ex_RegWr, ex_halt;
  mtr_t      ex_MemToReg;
  word_t     ex_addr, ex_store, ex_pc4, ex_lui;
  regbits_t  ex_wsel;
  logic      ex_ll, ex_sc, flush, dhit, ccinv;
  word_t     dmemload, ccsnoopaddr;
  logic      dmemREN, dmemWEN, mem_stall;
  word_t     dmemaddr, dmemstore;
  logic      wb_RegWr, wb_halt, halt;
  regbits_t  wb_wsel;
  word_t     wb_wdat;
  wait_cnt_t wait_cnt;

  int checks   = 0;
  int failures = 0;
  int stall_seen;

  mem_stage dut (
    .CLK(CLK), .RST(RST),
    .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_RegWr(ex_RegWr), .ex_halt(ex_halt),
    .ex_MemToReg(ex_MemToReg), .ex_addr(ex_addr), .ex_store(ex_store),
    .ex_pc4(ex_pc4), .ex_lui(ex_lui), .ex_wsel(ex_wsel),
    .ex_ll(ex_ll), .ex_sc(ex_sc), .flush(flush), .dhit(dhit), .dmemload(dmemload),
    .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .wb_RegWr(wb_RegWr), .wb_halt(wb_halt), .wb_wsel(wb_wsel),
    .wb_wdat(wb_wdat), .halt(halt), .wait_cnt(wait_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    ex_dREN = 1'b0; ex_dWEN = 1'b0; ex_RegWr = 1'b0; ex_halt = 1'b0;
    ex_MemToReg = MTR_ALU; ex_addr = '0; ex_store = '0; ex_pc4 = '0; ex_lui = '0;
    ex_wsel = '0; ex_ll = 1'b0; ex_sc = 1'b0; flush = 1'b0; dhit = 1'b0;
    dmemload = '0; ccinv = 1'b0; ccsnoopaddr = '0;
  endtask

  mtr_t  mtr_tab [5] = '{MTR_ALU, MTR_PC4, MTR_LUI, 3'd5, 3'd7};
  word_t wdat_tab[5] = '{32'h11, 32'h22, 32'h33, 32'h0, 32'h0};

  initial begin
    idle_in();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_wb_regwr", 32'(wb_RegWr), 32'd0);
    check("rst_wb_wdat", wb_wdat, 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_wait_cnt", 32'(wait_cnt), 32'd0);
    RST = 1'b0;

    // Load with three miss cycles
    ex_dREN = 1'b1; ex_addr = 32'h40; ex_RegWr = 1'b1; ex_wsel = 5'd5;
    ex_MemToReg = MTR_MEM; dmemload = 32'hDEADBEEF;
    #1;
    check("ld_dmemren", 32'(dmemREN), 32'd1);
    check("ld_dmemaddr", dmemaddr, 32'h40);
    stall_seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_stall) stall_seen++;
      tick();
      check("ld_bubble_regwr", 32'(wb_RegWr), 32'd0);
      check("ld_bubble_wdat", wb_wdat, 32'd0);
    end
    check("ld_stall_cycles", 32'(stall_seen), 32'd3);
    dhit = 1'b1;
    #1;
    check("ld_stall_end", 32'(mem_stall), 32'd0);
    tick();
    check("ld_wdat", wb_wdat, 32'hDEADBEEF);
    check("ld_regwr", 32'(wb_RegWr), 32'd1);
    check("ld_wsel", 32'(wb_wsel), 32'd5);
    check("ld_wait_cnt", 32'(wait_cnt), 32'd3);

    // Asynchronous reset clears MEM/WB immediately
    idle_in();
    RST = 1'b1;
    #1;
    check("rst_async_regwr", 32'(wb_RegWr), 32'd0);
    check("rst_async_wdat", wb_wdat, 32'd0);
    check("rst_async_wait_cnt", 32'(wait_cnt), 32'd0);
    tick();
    RST = 1'b0;

    // Store hitting in the same cycle
    ex_dWEN = 1'b1; ex_addr = 32'h100; ex_store = 32'h1234; dhit = 1'b1;
    #1;
    check("st_dmemwen", 32'(dmemWEN), 32'd1);
    check("st_dmemstore", dmemstore, 32'h1234);
    check("st_stall", 32'(mem_stall), 32'd0);
    tick();
    check("st_wait_cnt", 32'(wait_cnt), 32'd0);
    idle_in();
    #1;
    check("st_dmemwen_off", 32'(dmemWEN), 32'd0);

    // Writeback select table
    ex_addr = 32'h11; ex_pc4 = 32'h22; ex_lui = 32'h33; ex_RegWr = 1'b1; ex_wsel = 5'd3;
    for (int i = 0; i < 5; i++) begin
      ex_MemToReg = mtr_tab[i];
      tick();
      check("sel_wdat", wb_wdat, wdat_tab[i]);
      check("sel_regwr", 32'(wb_RegWr), 32'd1);
    end

    // Flush during a stall yields a bubble
    idle_in();
    ex_dREN = 1'b1; flush = 1'b1; ex_RegWr = 1'b1; ex_wsel = 5'd7; ex_addr = 32'h55;
    tick();
    check("fl_regwr", 32'(wb_RegWr), 32'd0);
    check("fl_wsel", 32'(wb_wsel), 32'd0);
    check("fl_wdat", wb_wdat, 32'd0);
    flush = 1'b0; dhit = 1'b1;
    tick();
    check("fl_after_wdat", wb_wdat, 32'h55);
    check("fl_after_wsel", 32'(wb_wsel), 32'd7);

    // Reset in the middle of a long access
    idle_in();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    ex_dREN = 1'b1; ex_addr = 32'h200; ex_RegWr = 1'b1; ex_wsel = 5'd9;
    repeat (5) tick();
    check("ra_wait_cnt", 32'(wait_cnt), 32'd5);
    #2;
    RST = 1'b1;
    #1;
    check("ra_wait_cnt_clr", 32'(wait_cnt), 32'd0);
    check("ra_wb_regwr", 32'(wb_RegWr), 32'd0);
    tick();
    RST = 1'b0;
    #1;
    check("ra_dmemren", 32'(dmemREN), 32'd1);
    check("ra_stall", 32'(mem_stall), 32'd1);
    dhit = 1'b1;
    tick();
    check("ra_done_wsel", 32'(wb_wsel), 32'd9);
    check("ra_wait_cnt_after", 32'(wait_cnt), 32'd0);

`ifdef LLSC_EN
    // LL then SC to the same address succeeds
    idle_in();
    ex_ll = 1'b1; ex_dREN = 1'b1; ex_addr = 32'h80; dhit = 1'b1;
    ex_RegWr = 1'b1; ex_MemToReg = MTR_MEM;
    tick();
    idle_in();
    ex_sc = 1'b1; ex_dWEN = 1'b1; ex_addr = 32'h80; dhit = 1'b1;
    ex_RegWr = 1'b1; ex_MemToReg = MTR_SC;
    #1;
    check("sc1_dmemwen", 32'(dmemWEN), 32'd1);
    tick();
    check("sc1_wdat", wb_wdat, 32'd1);
    // Link consumed: repeated SC fails without stalling
    dhit = 1'b0;
    #1;
    check("sc2_dmemwen", 32'(dmemWEN), 32'd0);
    check("sc2_stall", 32'(mem_stall), 32'd0);
    tick();
    check("sc2_wdat", wb_wdat, 32'd0);
    check("sc2_regwr", 32'(wb_RegWr), 32'd1);

    // Snoop invalidate between LL and SC
    idle_in();
    ex_ll = 1'b1; ex_dREN = 1'b1; ex_addr = 32'h80; dhit = 1'b1;
    tick();
    idle_in();
    ccinv = 1'b1; ccsnoopaddr = 32'h80;
    tick();
    idle_in();
    ex_sc = 1'b1; ex_dWEN = 1'b1; ex_addr = 32'h80; dhit = 1'b1;
    ex_RegWr = 1'b1; ex_MemToReg = MTR_SC;
    #1;
    check("sc3_dmemwen", 32'(dmemWEN), 32'd0);
    tick();
    check("sc3_wdat", wb_wdat, 32'd0);

    // Snoop in the same cycle the LL completes
    idle_in();
    ex_ll = 1'b1; ex_dREN = 1'b1; ex_addr = 32'h80; dhit = 1'b1;
    ccinv = 1'b1; ccsnoopaddr = 32'h80;
    tick();
    idle_in();
    ex_sc = 1'b1; ex_dWEN = 1'b1; ex_addr = 32'h80; dhit = 1'b1;
    ex_RegWr = 1'b1; ex_MemToReg = MTR_SC;
    #1;
    check("sc4_dmemwen", 32'(dmemWEN), 32'd0);
    tick();
    check("sc4_wdat", wb_wdat, 32'd0);
`else
    // Without reservations an SC is a plain store that reports success
    idle_in();
    ex_sc = 1'b1; ex_dWEN = 1'b1; ex_addr = 32'h80; dhit = 1'b1;
    ex_RegWr = 1'b1; ex_MemToReg = MTR_SC; ccinv = 1'b1; ccsnoopaddr = 32'h80;
    #1;
    check("sc_dmemwen", 32'(dmemWEN), 32'd1);
    tick();
    check("sc_wdat", wb_wdat, 32'd1);
`endif

    // Halt is terminal and blocks further memory requests
    idle_in();
    ex_halt = 1'b1;
    tick();
    check("hl_halt", 32'(halt), 32'd1);
    check("hl_wb_halt", 32'(wb_halt), 32'd1);
    idle_in();
    ex_dREN = 1'b1; ex_dWEN = 1'b1;
    #1;
    check("hl_dmemren", 32'(dmemREN), 32'd0);
    check("hl_dmemwen", 32'(dmemWEN), 32'd0);
    check("hl_stall", 32'(mem_stall), 32'd0);
    repeat (3) tick();
    check("hl_halt_sticky", 32'(halt), 32'd1);
    check("hl_wait_cnt", 32'(wait_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
